// File: rtl/fft_pkg.sv
// Constants and types shared by the spectrum BRAM writer and reader.
// The BRAM word address is bin*NUM_CH + ch.
package fft_pkg;
    localparam int NUM_CH  = 8;
    localparam int NUM_BIN = 256;
    localparam int SAMP_W  = 32;
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int BIN_W   = $clog2(NUM_BIN);
    localparam int ADDR_W  = $clog2(NUM_CH * NUM_BIN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        READ  = S_READ,
        DRAIN = S_DRAIN
    } rd_state_t;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [BIN_W-1:0] bin;
        logic             tlast;
        logic             frame_last;
    } tag_t;

    typedef struct packed {
        tag_t              tag;
        logic [SAMP_W-1:0] im;
        logic [SAMP_W-1:0] re;
    } beat_t;
endpackage

// File: rtl/fft_rd_fifo.sv
// Small synchronous FIFO with flop storage.
// The head entry is read straight from registers and is stable until popped.
module fft_rd_fifo #(
    parameter int  WIDTH = 77,
    parameter int  DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic [CNT_W-1:0] o_count
);
    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            r_count;
    logic                        w_push;
    logic                        w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/fft_bram_reader.sv
// Reads a completed FFT frame from spectrum BRAM port B and streams it
// channel-major on AXI-Stream; reads are credit-limited so returns always fit.
module fft_bram_reader
    import fft_pkg::SAMP_W, fft_pkg::CH_W, fft_pkg::BIN_W, fft_pkg::ADDR_W,
           fft_pkg::rd_state_t, fft_pkg::IDLE, fft_pkg::READ, fft_pkg::DRAIN,
           fft_pkg::tag_t, fft_pkg::beat_t;
#(
    parameter int NUM_CH     = fft_pkg::NUM_CH,
    parameter int NUM_BIN    = fft_pkg::NUM_BIN,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_done,
    output logic                    busy,
    output logic                    overrun_err,
    output logic [31:0]             bram_addr,
    output logic                    bram_en,
    input  logic [SAMP_W-1:0]       bram_dout_re,
    input  logic [SAMP_W-1:0]       bram_dout_im,
    output logic [2*SAMP_W-1:0]     m_axis_tdata,
    output logic [CH_W+BIN_W-1:0]   m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    frame_last
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LAT + 1);

    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [CH_W-1:0]    r_ch;
    logic [BIN_W-1:0]   r_bin;
    logic               r_overrun;
    logic [RD_LAT-1:0]  r_vld;
    tag_t [RD_LAT-1:0]  r_tag;
    logic [INF_W-1:0]   w_inflight;
    logic [CNT_W-1:0]   w_fifo_cnt;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_credit, w_issue, w_bin_last, w_last_rd;
    logic               w_push, w_pop;
    tag_t               w_tag;
    beat_t              w_din, w_head;

    assign w_inflight = INF_W'($countones(r_vld));
    // Every outstanding read already owns a FIFO slot, so a push can never find it full.
    assign w_credit   = (int'(w_fifo_cnt) + int'(w_inflight) + 1) <= FIFO_DEPTH;
    assign w_bin_last = (r_bin == BIN_W'(NUM_BIN - 1));
    assign w_last_rd  = w_bin_last && (r_ch == CH_W'(NUM_CH - 1));
    assign w_tag      = '{ch: r_ch, bin: r_bin, tlast: w_bin_last, frame_last: w_last_rd};
    assign w_addr     = ADDR_W'(r_bin) * ADDR_W'(NUM_CH) + ADDR_W'(r_ch);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE:  if (frame_done) w_state_nxt = READ;
            READ: begin
                w_issue = w_credit;
                if (w_credit && w_last_rd) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_inflight == '0 &&
                    (w_fifo_cnt == '0 || (w_fifo_cnt == CNT_W'(1) && w_pop)))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_bin     <= '0;
            r_overrun <= 1'b0;
            r_vld     <= '0;
            r_tag     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (frame_done && r_state != IDLE)
                r_overrun <= 1'b1;
            if (r_state == IDLE && frame_done) begin
                r_ch  <= '0;
                r_bin <= '0;
            end else if (w_issue) begin
                if (w_bin_last) begin
                    r_bin <= '0;
                    r_ch  <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
                end else begin
                    r_bin <= r_bin + BIN_W'(1);
                end
            end
            r_vld[0] <= w_issue;
            r_tag[0] <= w_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_push = r_vld[RD_LAT-1];
    assign w_din  = '{tag: r_tag[RD_LAT-1], im: bram_dout_im, re: bram_dout_re};
    assign w_pop  = m_axis_tvalid && m_axis_tready;

    fft_rd_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_fifo_cnt)
    );

    assign busy          = (r_state != IDLE);
    assign overrun_err   = r_overrun;
    assign bram_en       = w_issue;
    assign bram_addr     = {{(32 - ADDR_W){1'b0}}, w_addr};
    assign m_axis_tvalid = (w_fifo_cnt != '0);
    assign m_axis_tdata  = {w_head.im, w_head.re};
    assign m_axis_tuser  = {w_head.tag.ch, w_head.tag.bin};
    assign m_axis_tlast  = m_axis_tvalid && w_head.tag.tlast;
    assign frame_last    = m_axis_tvalid && w_head.tag.frame_last;
endmodule

// File: tb/tb_fft_bram_reader.sv
// Randomized bench for fft_bram_reader: RD_LAT=1 and RD_LAT=2 instances run side by side
// against a frame-order reference model and a behavioural BRAM (re=addr, im=~addr).
`timescale 1ns/1ps
module tb_fft_bram_reader;
    localparam int NB    = 2048;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_done = 1'b0;
    logic        tready = 1'b1;
    logic        busy[2], ovr[2], en[2], tvalid[2], tlast[2], flast[2];
    logic [31:0] addr[2], re[2], im[2], s1[2], s2[2];
    logic [63:0] tdata[2];
    logic [10:0] tuser[2];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, fd_cyc = 0;
    int exp_k[2], iss[2], ovf[2], first_lat[2];
    bit arm[2], last_hs[2], prev_stall[2], stop_rnd;
    logic [63:0] prev_data[2];
    int mk;
    logic [31:0] ma;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM port B: one register stage per cycle of read latency
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en[d]) s1[d] <= addr[d];
            s2[d] <= s1[d];
        end
    end
    assign re[0] = s1[0];
    assign im[0] = ~s1[0];
    assign re[1] = s2[1];
    assign im[1] = ~s2[1];

    fft_bram_reader #(.RD_LAT(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst), .frame_done(frame_done), .busy(busy[0]), .overrun_err(ovr[0]),
        .bram_addr(addr[0]), .bram_en(en[0]), .bram_dout_re(re[0]), .bram_dout_im(im[0]),
        .m_axis_tdata(tdata[0]), .m_axis_tuser(tuser[0]), .m_axis_tvalid(tvalid[0]),
        .m_axis_tready(tready), .m_axis_tlast(tlast[0]), .frame_last(flast[0]));

    fft_bram_reader #(.RD_LAT(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .frame_done(frame_done), .busy(busy[1]), .overrun_err(ovr[1]),
        .bram_addr(addr[1]), .bram_en(en[1]), .bram_dout_re(re[1]), .bram_dout_im(im[1]),
        .m_axis_tdata(tdata[1]), .m_axis_tuser(tuser[1]), .m_axis_tvalid(tvalid[1]),
        .m_axis_tready(tready), .m_axis_tlast(tlast[1]), .frame_last(flast[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame order is channel-major: beat j is channel j/256, bin j%256.
    function automatic logic [31:0] beat_addr(input int j);
        return 32'((j % 256) * 8 + j / 256);
    endfunction

    always @(negedge clk) begin
        if (u_dut0.u_fifo.i_push && u_dut0.u_fifo.o_count == DEPTH && !u_dut0.u_fifo.i_pop) ovf[0]++;
        if (u_dut1.u_fifo.i_push && u_dut1.u_fifo.o_count == DEPTH && !u_dut1.u_fifo.i_pop) ovf[1]++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                exp_k[d] = 0; iss[d] = 0; prev_stall[d] = 0; last_hs[d] = 0;
            end else begin
                if (last_hs[d]) begin
                    chk($sformatf("busy_after_last%0d", d), busy[d], 1'b0);
                    last_hs[d] = 0;
                end
                if (arm[d] && tvalid[d]) begin
                    first_lat[d] = cyc - fd_cyc;
                    arm[d] = 0;
                end
                if (prev_stall[d]) begin
                    chk($sformatf("hold_valid%0d", d), tvalid[d], 1'b1);
                    chk($sformatf("hold_data%0d", d), tdata[d], prev_data[d]);
                end
                if (en[d]) begin
                    chk($sformatf("rd_count%0d", d), iss[d] < NB, 1'b1);
                    chk($sformatf("rd_addr%0d[%0d]", d, iss[d]), addr[d], beat_addr(iss[d]));
                    iss[d]++;
                end
                if (tvalid[d] && tready) begin
                    mk = exp_k[d];
                    ma = beat_addr(mk);
                    chk($sformatf("beat_count%0d", d), mk < NB, 1'b1);
                    chk($sformatf("tdata%0d[%0d]", d, mk), tdata[d], {~ma, ma});
                    chk($sformatf("tuser%0d[%0d]", d, mk), tuser[d], {3'(mk / 256), 8'(mk % 256)});
                    chk($sformatf("last%0d[%0d]", d, mk), {tlast[d], flast[d]},
                        {(mk % 256) == 255, mk == NB - 1});
                    if (mk == NB - 1) last_hs[d] = 1;
                    exp_k[d]++;
                end
                prev_stall[d] = tvalid[d] && !tready;
                prev_data[d]  = tdata[d];
            end
        end
    end

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_busy%0d", tag, d), busy[d], 1'b0);
            chk($sformatf("%s_ovr%0d", tag, d), ovr[d], 1'b0);
            chk($sformatf("%s_en%0d", tag, d), en[d], 1'b0);
            chk($sformatf("%s_addr%0d", tag, d), addr[d], 32'd0);
            chk($sformatf("%s_tvalid%0d", tag, d), tvalid[d], 1'b0);
            chk($sformatf("%s_flags%0d", tag, d), {tlast[d], flast[d]}, 2'b00);
            chk($sformatf("%s_tdata%0d", tag, d), tdata[d], 64'd0);
            chk($sformatf("%s_tuser%0d", tag, d), tuser[d], 11'd0);
        end
    endtask

    task automatic start_frame();
        for (int d = 0; d < 2; d++) begin exp_k[d] = 0; iss[d] = 0; end
        @(posedge clk); #1 frame_done = 1'b1;
        @(posedge clk); #1 frame_done = 1'b0;
        fd_cyc = cyc;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy[0] && !busy[1]) break;
        end
        chk({tag, "_finished"}, {busy[0], busy[1]}, 2'b00);
        repeat (10) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_beats%0d", tag, d), exp_k[d], NB);
            chk($sformatf("%s_reads%0d", tag, d), iss[d], NB);
            chk($sformatf("%s_idle%0d", tag, d), busy[d], 1'b0);
        end
    endtask

    task automatic wait_beat(input int n);
        for (int i = 0; i < 20000 && exp_k[0] < n; i++) @(negedge clk);
        chk($sformatf("reach_beat%0d", n), exp_k[0] >= n, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_reset("por");
        rst = 1'b0;

        // full-rate frame, latency and tagging
        tready = 1'b1;
        arm[0] = 1; arm[1] = 1;
        start_frame();
        @(negedge clk);
        chk("busy_set0", busy[0], 1'b1);
        chk("busy_set1", busy[1], 1'b1);
        wait_done("f1");
        chk("first_lat0", first_lat[0], 2);
        chk("first_lat1", first_lat[1], 3);

        // random backpressure
        stop_rnd = 0;
        fork
            while (!stop_rnd) begin
                @(posedge clk); #1 tready = 1'($urandom % 2);
            end
        join_none
        start_frame();
        wait_done("rnd");
        stop_rnd = 1;
        @(posedge clk); #2 tready = 1'b1;

        // stalled sink: credit caps outstanding reads
        tready = 1'b0;
        start_frame();
        repeat (100) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("stall_reads%0d", d), iss[d], DEPTH);
            chk($sformatf("stall_en%0d", d), en[d], 1'b0);
            chk($sformatf("stall_valid%0d", d), tvalid[d], 1'b1);
        end
        @(posedge clk); #1 tready = 1'b1;
        wait_done("stall");

        // overlapping frame_done
        start_frame();
        wait_beat(500);
        @(posedge clk); #1 frame_done = 1'b1;
        @(posedge clk); #1 frame_done = 1'b0;
        @(negedge clk);
        chk("ovr_set0", ovr[0], 1'b1);
        chk("ovr_set1", ovr[1], 1'b1);
        wait_done("ovr");
        chk("ovr_sticky0", ovr[0], 1'b1);
        chk("ovr_sticky1", ovr[1], 1'b1);

        // reset mid-frame, then a clean frame
        start_frame();
        wait_beat(1000);
        @(posedge clk); #1 rst = 1'b1;
        #1 chk_reset("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start_frame();
        wait_done("post_rst");

        chk("no_overflow0", ovf[0], 0);
        chk("no_overflow1", ovf[1], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
